// File: rtl/debug_uart_pkg.sv
// Shared types and elaboration-time helpers for the buffered debug UART transmitter.
package debug_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   function automatic int calc_clks_per_bit(input int clk_hz, input int bit_rate);
      if (bit_rate <= 0) return 0;
      return clk_hz / bit_rate;
   endfunction

   // Bit period must be a whole number of clocks (at least two), and the FIFO a power of two.
   function automatic bit params_ok(input int clk_hz, input int bit_rate, input int depth);
      return (bit_rate > 0) && (clk_hz % bit_rate == 0) && (clk_hz / bit_rate >= 2) &&
             (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/debug_uart_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; the head byte is visible on dout while not empty.
module debug_uart_fifo
   import debug_uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [7:0]                 din,
   output logic [7:0]                 dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        push_ok;
   logic        pop_ok;

   // A push into a full FIFO still fits when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;

   assign level = wr_ptr - rd_ptr;
   assign full  = (level == (AW + 1)'(DEPTH));
   assign empty = (wr_ptr == rd_ptr);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/debug_uart_tx_buffered.sv
// Debug UART transmitter: CPU byte writes queue in a FIFO and drain as contiguous 8N1 frames.
module debug_uart_tx_buffered
   import debug_uart_pkg::*;
#(
   parameter int CLK_HZ   = 4_000_000,
   parameter int BIT_RATE = 1_000_000,
   parameter int DEPTH    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   input  logic                       clr_overflow,
   output logic                       uart_txd,
   output logic                       tx_busy,
   output logic                       fifo_full,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BIT_RATE);
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   if (!params_ok(CLK_HZ, BIT_RATE, DEPTH)) begin : g_bad_params
      $error("debug_uart_tx_buffered: CLK_HZ/BIT_RATE must be an integer >= 2 and DEPTH a power of two >= 2");
   end

   uart_state_t      state, next_state;
   logic [CNT_W-1:0] baud_cnt, next_cnt;
   logic [2:0]       bit_idx, next_bit_idx;
   logic [7:0]       shift, next_shift;
   logic             txd_next;
   logic             pop;
   logic             baud_last;
   logic             drop;
   logic [7:0]       fifo_dout;
   logic             fifo_empty;

   debug_uart_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .pop   (pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign baud_last = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign drop      = wr_en & fifo_full & ~pop;
   assign tx_busy   = (state != IDLE) | (fifo_level != '0);

   // The line level is derived from the next state so uart_txd stays a pure register.
   always_comb begin
      next_state   = state;
      next_cnt     = baud_cnt + CNT_W'(1);
      next_bit_idx = bit_idx;
      next_shift   = shift;
      pop          = 1'b0;
      txd_next     = 1'b1;
      case (state)
         IDLE: begin
            next_cnt = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               next_shift = fifo_dout;
               next_state = START;
            end
         end
         START: begin
            if (baud_last) begin
               next_cnt     = '0;
               next_bit_idx = '0;
               next_state   = DATA;
            end
         end
         DATA: begin
            if (baud_last) begin
               next_cnt   = '0;
               next_shift = shift >> 1;
               if (bit_idx == 3'd7) next_state = STOP;
               else                 next_bit_idx = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (baud_last) begin
               next_cnt = '0;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  next_shift = fifo_dout;
                  next_state = START;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
      case (next_state)
         START:   txd_next = 1'b0;
         DATA:    txd_next = next_shift[0];
         default: txd_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         uart_txd <= 1'b1;
      end else begin
         state    <= next_state;
         baud_cnt <= next_cnt;
         bit_idx  <= next_bit_idx;
         shift    <= next_shift;
         uart_txd <= txd_next;
      end
   end

   // A dropped write outranks a simultaneous clear so no loss goes unreported.
   always_ff @(posedge clk) begin
      if (rst)               overflow <= 1'b0;
      else if (drop)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
   end

endmodule

// File: tb/tb_debug_uart_tx_buffered.sv
// Self-checking bench: a mid-bit sampling receiver feeds frames that are matched against a byte scoreboard.
module tb_debug_uart_tx_buffered;

   localparam int DEPTH = 8;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   wr_en = 1'b0;
   logic [7:0]             wr_data = 8'h00;
   logic                   clr_overflow = 1'b0;
   logic                   uart_txd;
   logic                   tx_busy;
   logic                   fifo_full;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   overflow;

   int passed = 0;
   int total  = 0;
   logic [7:0] exp_q[$];

   debug_uart_tx_buffered #(.CLK_HZ(4_000_000), .BIT_RATE(1_000_000), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .clr_overflow (clr_overflow),
      .uart_txd     (uart_txd),
      .tx_busy      (tx_busy),
      .fifo_full    (fifo_full),
      .fifo_level   (fifo_level),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Receiver: offset 0 is the first negedge showing the start bit; each bit is sampled at offset 4k+2.
   int         mon_off = -1;
   int         mon_cyc0 = 0;
   logic [7:0] mon_shift = 8'h00;
   logic       mon_start_ok = 1'b0;
   int         rx_count = 0;
   logic [7:0] rx_byte [0:63];
   logic       rx_start_ok [0:63];
   logic       rx_stop_ok [0:63];
   int         rx_start_cyc [0:63];

   always @(negedge clk) begin
      if (rst) begin
         mon_off <= -1;
      end else if (mon_off < 0) begin
         if (uart_txd === 1'b0) begin
            mon_off  <= 1;
            mon_cyc0 <= cyc;
         end
      end else begin
         mon_off <= mon_off + 1;
         if (mon_off == 2) begin
            mon_start_ok <= (uart_txd === 1'b0);
         end else if (mon_off >= 6 && mon_off <= 34 && (mon_off % 4) == 2) begin
            mon_shift <= {uart_txd, mon_shift[7:1]};
         end else if (mon_off == 38) begin
            if (rx_count < 64) begin
               rx_byte[rx_count]      <= mon_shift;
               rx_start_ok[rx_count]  <= mon_start_ok;
               rx_stop_ok[rx_count]   <= (uart_txd === 1'b1);
               rx_start_cyc[rx_count] <= mon_cyc0;
            end
            rx_count <= rx_count + 1;
            mon_off  <= -1;
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (uart_txd !== 1'b1) $display("[TB] FAIL reset_txd got %b want 1", uart_txd); else passed++;
      total++; if (tx_busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", tx_busy); else passed++;
      total++; if (fifo_full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", fifo_full); else passed++;
      total++; if (fifo_level !== 4'd0) $display("[TB] FAIL reset_level got %0d want 0", fifo_level); else passed++;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow got %b want 0", overflow); else passed++;
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         total++;
         if ({uart_txd, tx_busy, fifo_level} !== {1'b1, 1'b0, 4'd0})
            $display("[TB] FAIL idle_hold cycle %0d got txd=%b busy=%b level=%0d want 1/0/0", i, uart_txd, tx_busy, fifo_level);
         else passed++;
      end
   endtask

   task automatic test_single();
      int base;
      logic [7:0] exp_b;
      base = rx_count;
      wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
      @(negedge clk);
      wr_en = 1'b0;
      total++; if (fifo_level !== 4'd1) $display("[TB] FAIL single_level_after_write got %0d want 1", fifo_level); else passed++;
      total++; if (uart_txd !== 1'b1) $display("[TB] FAIL single_txd_before_pop got %b want 1", uart_txd); else passed++;
      @(negedge clk);
      total++; if (uart_txd !== 1'b0) $display("[TB] FAIL single_start_edge got %b want 0", uart_txd); else passed++;
      total++; if (fifo_level !== 4'd0) $display("[TB] FAIL single_level_after_pop got %0d want 0", fifo_level); else passed++;
      repeat (39) @(negedge clk);
      total++; if (tx_busy !== 1'b1) $display("[TB] FAIL single_busy_last_stop got %b want 1", tx_busy); else passed++;
      @(negedge clk);
      total++; if (tx_busy !== 1'b0) $display("[TB] FAIL single_busy_after_frame got %b want 0", tx_busy); else passed++;
      total++; if (rx_count !== base + 1) $display("[TB] FAIL single_frame_count got %0d want %0d", rx_count - base, 1); else passed++;
      for (int i = base; i < rx_count && i < 64; i++) begin
         total++;
         if (exp_q.size() == 0) $display("[TB] FAIL single_unexpected_frame got %h want none", rx_byte[i]);
         else begin
            exp_b = exp_q.pop_front();
            if (rx_byte[i] !== exp_b || rx_start_ok[i] !== 1'b1 || rx_stop_ok[i] !== 1'b1)
               $display("[TB] FAIL single_frame got %h start=%b stop=%b want %h start=1 stop=1", rx_byte[i], rx_start_ok[i], rx_stop_ok[i], exp_b);
            else passed++;
         end
      end
      total++; if (exp_q.size() != 0) $display("[TB] FAIL single_missing got %0d frames short want 0", exp_q.size()); else passed++;
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int base;
      int peak;
      int waited;
      logic [7:0] exp_b;
      base = rx_count; peak = 0; waited = 0;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'(i + 1); exp_q.push_back(8'(i + 1));
         @(negedge clk);
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      wr_en = 1'b0;
      while (rx_count < base + 3 && waited < 200) begin
         @(negedge clk);
         waited++;
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      total++; if (rx_count < base + 3) $display("[TB] FAIL b2b_timeout got %0d frames want 3", rx_count - base); else passed++;
      total++; if (peak !== 2) $display("[TB] FAIL b2b_level_peak got %0d want 2", peak); else passed++;
      total++; if (rx_start_cyc[base+1] - rx_start_cyc[base] !== 40) $display("[TB] FAIL b2b_gap01 got %0d want 40", rx_start_cyc[base+1] - rx_start_cyc[base]); else passed++;
      total++; if (rx_start_cyc[base+2] - rx_start_cyc[base+1] !== 40) $display("[TB] FAIL b2b_gap12 got %0d want 40", rx_start_cyc[base+2] - rx_start_cyc[base+1]); else passed++;
      repeat (4) @(negedge clk);
      total++; if (tx_busy !== 1'b0) $display("[TB] FAIL b2b_busy_end got %b want 0", tx_busy); else passed++;
      for (int i = base; i < rx_count && i < 64; i++) begin
         total++;
         if (exp_q.size() == 0) $display("[TB] FAIL b2b_unexpected_frame got %h want none", rx_byte[i]);
         else begin
            exp_b = exp_q.pop_front();
            if (rx_byte[i] !== exp_b || rx_start_ok[i] !== 1'b1 || rx_stop_ok[i] !== 1'b1)
               $display("[TB] FAIL b2b_frame got %h start=%b stop=%b want %h start=1 stop=1", rx_byte[i], rx_start_ok[i], rx_stop_ok[i], exp_b);
            else passed++;
         end
      end
      total++; if (exp_q.size() != 0) $display("[TB] FAIL b2b_missing got %0d frames short want 0", exp_q.size()); else passed++;
      exp_q.delete();
   endtask

   task automatic test_overflow();
      int base;
      int waited;
      logic [7:0] exp_b;
      base = rx_count; waited = 0;
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
         if (i < 9) exp_q.push_back(8'h30 + 8'(i));
         @(negedge clk);
         if (i == 8) begin
            total++; if (fifo_full !== 1'b1) $display("[TB] FAIL ovf_full got %b want 1", fifo_full); else passed++;
            total++; if (fifo_level !== 4'd8) $display("[TB] FAIL ovf_level got %0d want 8", fifo_level); else passed++;
            total++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_early got %b want 0", overflow); else passed++;
         end
      end
      total++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_set got %b want 1", overflow); else passed++;
      total++; if (fifo_level !== 4'd8) $display("[TB] FAIL ovf_level_hold got %0d want 8", fifo_level); else passed++;
      wr_data = 8'hEE; clr_overflow = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      total++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_set_beats_clear got %b want 1", overflow); else passed++;
      @(negedge clk);
      clr_overflow = 1'b0;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_clear got %b want 0", overflow); else passed++;
      while (rx_count < base + 9 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      total++; if (rx_count < base + 9) $display("[TB] FAIL ovf_timeout got %0d frames want 9", rx_count - base); else passed++;
      repeat (60) @(negedge clk);
      total++; if (rx_count !== base + 9) $display("[TB] FAIL ovf_frame_count got %0d want 9", rx_count - base); else passed++;
      total++; if (tx_busy !== 1'b0) $display("[TB] FAIL ovf_busy_end got %b want 0", tx_busy); else passed++;
      for (int i = base; i < rx_count && i < 64; i++) begin
         total++;
         if (exp_q.size() == 0) $display("[TB] FAIL ovf_unexpected_frame got %h want none", rx_byte[i]);
         else begin
            exp_b = exp_q.pop_front();
            if (rx_byte[i] !== exp_b || rx_start_ok[i] !== 1'b1 || rx_stop_ok[i] !== 1'b1)
               $display("[TB] FAIL ovf_frame got %h start=%b stop=%b want %h start=1 stop=1", rx_byte[i], rx_start_ok[i], rx_stop_ok[i], exp_b);
            else passed++;
         end
      end
      total++; if (exp_q.size() != 0) $display("[TB] FAIL ovf_missing got %0d frames short want 0", exp_q.size()); else passed++;
      exp_q.delete();
   endtask

   task automatic test_full_push_pop();
      int base;
      int waited;
      logic [7:0] exp_b;
      base = rx_count; waited = 0;
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; wr_data = 8'h50 + 8'(i); exp_q.push_back(8'h50 + 8'(i));
         @(negedge clk);
      end
      wr_en = 1'b0;
      repeat (32) @(negedge clk);
      total++; if (fifo_full !== 1'b1) $display("[TB] FAIL fpp_full_before got %b want 1", fifo_full); else passed++;
      wr_en = 1'b1; wr_data = 8'h99; exp_q.push_back(8'h99);
      @(negedge clk);
      wr_en = 1'b0;
      total++; if (fifo_level !== 4'd8) $display("[TB] FAIL fpp_level got %0d want 8", fifo_level); else passed++;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL fpp_overflow got %b want 0", overflow); else passed++;
      while (rx_count < base + 10 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      total++; if (rx_count < base + 10) $display("[TB] FAIL fpp_timeout got %0d frames want 10", rx_count - base); else passed++;
      for (int i = base; i < rx_count && i < 64; i++) begin
         total++;
         if (exp_q.size() == 0) $display("[TB] FAIL fpp_unexpected_frame got %h want none", rx_byte[i]);
         else begin
            exp_b = exp_q.pop_front();
            if (rx_byte[i] !== exp_b || rx_start_ok[i] !== 1'b1 || rx_stop_ok[i] !== 1'b1)
               $display("[TB] FAIL fpp_frame got %h start=%b stop=%b want %h start=1 stop=1", rx_byte[i], rx_start_ok[i], rx_stop_ok[i], exp_b);
            else passed++;
         end
      end
      total++; if (exp_q.size() != 0) $display("[TB] FAIL fpp_missing got %0d frames short want 0", exp_q.size()); else passed++;
      exp_q.delete();
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int base;
      base = rx_count;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      // 0x60 has bit 3 clear, so the line is low in the middle of data bit 3.
      repeat (14) @(negedge clk);
      total++; if (uart_txd !== 1'b0) $display("[TB] FAIL rmf_bit3 got %b want 0", uart_txd); else passed++;
      total++; if (fifo_level !== 4'd4) $display("[TB] FAIL rmf_level_before got %0d want 4", fifo_level); else passed++;
      rst = 1'b1;
      @(negedge clk);
      total++; if (uart_txd !== 1'b1) $display("[TB] FAIL rmf_txd got %b want 1", uart_txd); else passed++;
      total++; if (fifo_level !== 4'd0) $display("[TB] FAIL rmf_level got %0d want 0", fifo_level); else passed++;
      total++; if (tx_busy !== 1'b0) $display("[TB] FAIL rmf_busy got %b want 0", tx_busy); else passed++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         total++;
         if ({uart_txd, tx_busy} !== 2'b10)
            $display("[TB] FAIL rmf_quiet cycle %0d got txd=%b busy=%b want 1/0", i, uart_txd, tx_busy);
         else passed++;
      end
      total++; if (rx_count !== base) $display("[TB] FAIL rmf_frames got %0d want 0", rx_count - base); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
